// File: rtl/muldiv_stall_unit_if.sv
// Handshake bundle between the core pipeline and the iterative mult/div unit.
// The core drives the master side, the unit sits on the slave side.
interface muldiv_stall_unit_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic [1:0]       OpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             MdUseD;
    logic             WeHiW;
    logic             WeLoW;
    logic [WIDTH-1:0] WdW;
    logic             Busy;
    logic             MdStallD;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, MdUseD, WeHiW, WeLoW, WdW,
        input  Busy, MdStallD, Hi, Lo
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, MdUseD, WeHiW, WeLoW, WdW,
        output Busy, MdStallD, Hi, Lo
    );
endinterface

// File: rtl/muldiv_stall_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO and hazard stall request.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the multiplier bits run out.
module muldiv_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_stall_unit_if.slave  md
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t             state_q;
    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    // Multiply: acc = product, bop = shifted multiplicand.
    // Divide:   acc = {remainder, dividend/quotient}, bop[WIDTH-1:0] = divisor.
    logic [2*WIDTH-1:0] acc_q, bop_q;
    logic [WIDTH-1:0]   mplier_q;

    logic [2*WIDTH-1:0] acc_d, bop_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               a_neg, b_neg, b_zero, early_out;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign a_neg  = md.OpE[0] & md.SrcAE[WIDTH-1];
    assign b_neg  = md.OpE[0] & md.SrcBE[WIDTH-1];
    assign b_zero = (md.SrcBE == '0);
    assign a_mag  = a_neg ? -md.SrcAE : md.SrcAE;
    assign b_mag  = b_neg ? -md.SrcBE : md.SrcBE;

    always_comb begin
        acc_d    = acc_q;
        bop_d    = bop_q;
        mplier_d = mplier_q;
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = WIDTH'(rem_sh - {1'b0, bop_q[WIDTH-1:0]});
        if (is_div_q) begin
            if (rem_sh >= {1'b0, bop_q[WIDTH-1:0]})
                acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            if (mplier_q[0])
                acc_d = acc_q + bop_q;
            bop_d    = bop_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Shifting the multiplicand (not the product) keeps the product aligned,
    // so stopping early needs no realignment.
`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !is_div_q && (mplier_d == '0);
`else
    assign early_out = 1'b0;
`endif

    assign prod_s = neg_res_q ? -acc_q : acc_q;
    assign quo_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            bop_q     <= '0;
            mplier_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md.WeHiW) hi_q <= md.WdW;
                    if (md.WeLoW) lo_q <= md.WdW;
                    if (md.StartE) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= CW'(WIDTH);
                        is_div_q  <= md.OpE[1];
                        // Divide by zero must leave the all-ones quotient un-negated.
                        neg_res_q <= (a_neg ^ b_neg) & ~(md.OpE[1] & b_zero);
                        neg_rem_q <= a_neg;
                        if (md.OpE[1]) begin
                            acc_q    <= {{WIDTH{1'b0}}, a_mag};
                            bop_q    <= {{WIDTH{1'b0}}, b_mag};
                            mplier_q <= '0;
                        end else begin
                            acc_q    <= '0;
                            bop_q    <= {{WIDTH{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                        end
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    bop_q    <= bop_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1) || early_out)
                        state_q <= SIGN;
                end
                SIGN: begin
                    if (is_div_q) begin
                        hi_q <= rem_s;
                        lo_q <= quo_s;
                    end else begin
                        {hi_q, lo_q} <= prod_s;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md.Busy     = busy_q;
    assign md.MdStallD = busy_q & md.MdUseD;
    assign md.Hi       = hi_q;
    assign md.Lo       = lo_q;
endmodule

// File: tb/tb_muldiv_stall_unit.sv
// Randomized bench for muldiv_stall_unit against an arithmetic reference model.
module tb_muldiv_stall_unit;
    logic clk = 1'b0;
    logic reset;
    bit   proto_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_stall_unit_if #(.WIDTH(32)) bus();

    muldiv_stall_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    // The hazard stall should keep these from ever reaching a busy unit.
    always @(posedge clk)
        if (!reset && proto_en)
            assert (!(bus.Busy && (bus.StartE || bus.WeHiW || bus.WeLoW)))
                else $error("protocol: mult/div or HI/LO write issued while busy");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 2'b10) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int h;
        if (!op[1]) begin
            m = (op[0] && b[31]) ? -b : b;
            h = -1;
            for (int i = 0; i < 32; i++) if (m[i]) h = i;
            return (h < 0) ? 2 : h + 2;
        end
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mt, input bit abuse, input string tag);
        logic [31:0] eh, el;
        int exp_len, n, serr;
        model(op, a, b, eh, el);
        exp_len = exp_busy(op, b);
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        if (mt) begin
            bus.WeHiW = 1'b1;
            bus.WdW   = 32'h5A5A_0001;
        end
        tick();
        bus.StartE = 1'b0;
        bus.WeHiW  = 1'b0;
        if (mt) chk({tag, "_mthi"}, bus.Hi, 32'h5A5A_0001);
        n = 0;
        serr = 0;
        while (bus.Busy && n < 200) begin
            bus.MdUseD = 1'($urandom_range(0, 1));
            #1;
            if (bus.MdStallD !== (bus.MdUseD && (n < exp_len))) serr++;
            if (abuse && n > 0) begin
                bus.StartE = 1'b1;
                bus.OpE    = 2'($urandom);
                bus.SrcAE  = $urandom;
                bus.SrcBE  = $urandom;
                bus.WeHiW  = 1'b1;
                bus.WeLoW  = 1'b1;
                bus.WdW    = $urandom;
            end
            n++;
            tick();
        end
        bus.StartE = 1'b0;
        bus.WeHiW  = 1'b0;
        bus.WeLoW  = 1'b0;
        bus.MdUseD = 1'b1;
        #1;
        if (bus.MdStallD !== 1'b0) serr++;
        bus.MdUseD = 1'b0;
        chk({tag, "_busy"}, n, exp_len);
        chk({tag, "_hi"}, bus.Hi, eh);
        chk({tag, "_lo"}, bus.Lo, el);
        chk({tag, "_stall"}, serr, 0);
    endtask

    task automatic mt_write(input bit hi, input logic [31:0] d);
        bus.WeHiW = hi;
        bus.WeLoW = !hi;
        bus.WdW   = d;
        tick();
        bus.WeHiW = 1'b0;
        bus.WeLoW = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0, 3:    return $urandom;
            1:       return 32'($urandom_range(0, 15));
            default: return sp[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        proto_en   = 1'b1;
        bus.StartE = 1'b0;
        bus.OpE    = 2'b00;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.MdUseD = 1'b1;
        bus.WeHiW  = 1'b0;
        bus.WeLoW  = 1'b0;
        bus.WdW    = '0;
        repeat (2) tick();
        chk("rst_busy", bus.Busy, 0);
        chk("rst_stall", bus.MdStallD, 0);
        chk("rst_hi", bus.Hi, 0);
        chk("rst_lo", bus.Lo, 0);
        reset = 1'b0;
        bus.MdUseD = 1'b0;
        tick();

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7,        0, 0, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,        0, 0, "div_neg");
        run_op(2'b10, 32'd100,       32'd7,        0, 0, "divu");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        run_op(2'b10, 32'h0000_1234, 32'h0,        0, 0, "divu_zero");
        run_op(2'b11, 32'hFFFF_FF00, 32'h0,        0, 0, "div_zero");
        run_op(2'b00, 32'd9,         32'd1,        0, 0, "multu_9x1");
        run_op(2'b01, 32'd123,       32'h0,        0, 0, "mult_b0");

        mt_write(1'b0, 32'hA5A5_A5A5);
        chk("mtlo", bus.Lo, 32'hA5A5_A5A5);
        mt_write(1'b1, 32'h3C3C_0F0F);
        chk("mthi", bus.Hi, 32'h3C3C_0F0F);

        run_op(2'b00, 32'd3, 32'd4, 1, 0, "start_mthi");

        // Reset in the tenth RUN cycle of MULT 5*5 discards everything.
        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        bus.StartE = 1'b1;
        bus.OpE    = 2'b01;
        bus.SrcAE  = 32'd5;
        bus.SrcBE  = 32'd5;
        tick();
        bus.StartE = 1'b0;
        repeat (9) tick();
        chk("midrst_busy_pre", bus.Busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", bus.Busy, 0);
        chk("midrst_hi", bus.Hi, 0);
        chk("midrst_lo", bus.Lo, 0);
        repeat (3) tick();
        chk("midrst_idle", bus.Busy, 0);

        // Illegal traffic while busy must not disturb the running MULT.
        proto_en = 1'b0;
        run_op(2'b01, 32'd5, 32'd5, 0, 1, "busy_ignore");
        tick();
        proto_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 4) == 0) begin
                mt_write(1'($urandom_range(0, 1)), $urandom);
            end
            run_op(op, a, b, 0, 0, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
